// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready handshakes on input and output.
module seq_divider #(
   parameter int WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [DW-1:0]    work;
   logic [WIDTH:0]   part_rem;
   logic [WIDTH-1:0] dsor;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;

   // work starts as the dividend and fills with quotient bits from the right,
   // so after 2W steps it holds the whole quotient with no truncation.
   always_comb begin
      shifted  = {part_rem[WIDTH-1:0], work[DW-1]};
      diff     = shifted - {1'b0, dsor};
      q_bit    = (shifted >= {1'b0, dsor});
      rem_next = q_bit ? diff : shifted;
   end

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         work        <= '0;
         part_rem    <= '0;
         dsor        <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dsor     <= divisor;
                  work     <= dividend;
                  part_rem <= '0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[WIDTH-1:0];
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     count <= CW'(DW);
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               work     <= {work[DW-2:0], q_bit};
               part_rem <= rem_next;
               count    <= count - CW'(1);
               if (count == CW'(1)) begin
                  quotient    <= {work[DW-2:0], q_bit};
                  remainder   <= rem_next[WIDTH-1:0];
                  div_by_zero <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               // out_valid trails entry into DONE by one edge, which sets the
               // accept-to-result latency; the result handshake needs it high.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep bench for seq_divider at WIDTH=2 and WIDTH=4.
module tb_seq_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       in_valid2, in_ready2, out_valid2, out_ready2, dz2;
   logic [3:0] dividend2, quotient2;
   logic [1:0] divisor2, remainder2;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, dz4;
   logic [7:0] dividend4, quotient4;
   logic [3:0] divisor4, remainder4;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(2)) u_div2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .dividend(dividend2), .divisor(divisor2), .out_valid(out_valid2),
      .out_ready(out_ready2), .quotient(quotient2), .remainder(remainder2),
      .div_by_zero(dz2));

   seq_divider #(.WIDTH(4)) u_div4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .dividend(dividend4), .divisor(divisor4), .out_valid(out_valid4),
      .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4),
      .div_by_zero(dz4));

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one operation, drives garbage while busy, waits for the result,
   // stalls out_ready while checking the result holds, then completes the handshake.
   task automatic applyStimulus2(input logic [3:0] a, input logic [1:0] b, input int pre,
                                 input int stall, output int lat, output logic [3:0] q,
                                 output logic [1:0] r, output logic dz);
      int guard;
      repeat (pre) @(negedge clk);
      in_valid2 = 1'b1; dividend2 = a; divisor2 = b;
      guard = 0;
      while (!in_ready2 && guard < 100) begin @(negedge clk); guard++; end
      @(posedge clk);
      @(negedge clk);
      dividend2 = ~a; divisor2 = ~b;
      lat = 0;
      do begin @(negedge clk); in_valid2 = 1'b0; lat++; end while (!out_valid2 && lat < 100);
      q = quotient2; r = remainder2; dz = dz2;
      for (int i = 0; i < stall; i++) begin
         checkOutput("hold2", 32'({out_valid2, in_ready2, dz2, quotient2, remainder2}),
                     32'({1'b1, 1'b0, dz, q, r}));
         @(negedge clk);
      end
      out_ready2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready2 = 1'b0;
      checkOutput("idle2", 32'({out_valid2, in_ready2}), 32'(2'b01));
   endtask

   task automatic applyStimulus4(input logic [7:0] a, input logic [3:0] b, input int pre,
                                 input int stall, output int lat, output logic [7:0] q,
                                 output logic [3:0] r, output logic dz);
      int guard;
      repeat (pre) @(negedge clk);
      in_valid4 = 1'b1; dividend4 = a; divisor4 = b;
      guard = 0;
      while (!in_ready4 && guard < 100) begin @(negedge clk); guard++; end
      @(posedge clk);
      @(negedge clk);
      dividend4 = ~a; divisor4 = ~b;
      lat = 0;
      do begin @(negedge clk); in_valid4 = 1'b0; lat++; end while (!out_valid4 && lat < 100);
      q = quotient4; r = remainder4; dz = dz4;
      for (int i = 0; i < stall; i++) begin
         checkOutput("hold4", 32'({out_valid4, in_ready4, dz4, quotient4, remainder4}),
                     32'({1'b1, 1'b0, dz, q, r}));
         @(negedge clk);
      end
      out_ready4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready4 = 1'b0;
      checkOutput("idle4", 32'({out_valid4, in_ready4}), 32'(2'b01));
   endtask

   task automatic checkResult2(input string tag, input logic [3:0] a, input logic [1:0] b,
                               input int lat, input logic [3:0] q, input logic [1:0] r,
                               input logic dz);
      int eq, er, elat;
      if (b == 2'd0) begin eq = 15; er = int'(a) % 4; elat = 1; end
      else begin eq = int'(a) / int'(b); er = int'(a) % int'(b); elat = 5; end
      checkOutput($sformatf("%s %0d/%0d quotient", tag, a, b), 32'(q), 32'(eq));
      checkOutput($sformatf("%s %0d/%0d remainder", tag, a, b), 32'(r), 32'(er));
      checkOutput($sformatf("%s %0d/%0d dbz", tag, a, b), 32'(dz), 32'(b == 2'd0));
      checkOutput($sformatf("%s %0d/%0d latency", tag, a, b), 32'(lat), 32'(elat));
   endtask

   task automatic checkResult4(input string tag, input logic [7:0] a, input logic [3:0] b,
                               input int lat, input logic [7:0] q, input logic [3:0] r,
                               input logic dz);
      int eq, er, elat;
      if (b == 4'd0) begin eq = 255; er = int'(a) % 16; elat = 1; end
      else begin eq = int'(a) / int'(b); er = int'(a) % int'(b); elat = 9; end
      checkOutput($sformatf("%s %0d/%0d quotient", tag, a, b), 32'(q), 32'(eq));
      checkOutput($sformatf("%s %0d/%0d remainder", tag, a, b), 32'(r), 32'(er));
      checkOutput($sformatf("%s %0d/%0d dbz", tag, a, b), 32'(dz), 32'(b == 4'd0));
      checkOutput($sformatf("%s %0d/%0d latency", tag, a, b), 32'(lat), 32'(elat));
   endtask

   initial begin
      int lat;
      logic [3:0] q2;
      logic [1:0] r2;
      logic [7:0] q4;
      logic [3:0] r4;
      logic dz;

      rst_n = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; dividend2 = '0; divisor2 = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; dividend4 = '0; divisor4 = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset2", 32'({in_ready2, out_valid2, dz2, quotient2, remainder2}),
                  32'({1'b1, 1'b0, 1'b0, 4'd0, 2'd0}));
      checkOutput("reset4", 32'({in_ready4, out_valid4, dz4, quotient4, remainder4}),
                  32'({1'b1, 1'b0, 1'b0, 8'd0, 4'd0}));
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus2(4'd9, 2'd2, 0, 0, lat, q2, r2, dz);
      checkResult2("t1", 4'd9, 2'd2, lat, q2, r2, dz);
      applyStimulus2(4'd15, 2'd3, 1, 0, lat, q2, r2, dz);
      checkResult2("t2a", 4'd15, 2'd3, lat, q2, r2, dz);
      applyStimulus2(4'd6, 2'd3, 0, 1, lat, q2, r2, dz);
      checkResult2("t2b", 4'd6, 2'd3, lat, q2, r2, dz);
      applyStimulus2(4'd7, 2'd0, 0, 0, lat, q2, r2, dz);
      checkResult2("t3", 4'd7, 2'd0, lat, q2, r2, dz);
      applyStimulus2(4'd11, 2'd3, 0, 10, lat, q2, r2, dz);
      checkResult2("t4a", 4'd11, 2'd3, lat, q2, r2, dz);
      applyStimulus2(4'd4, 2'd1, 0, 0, lat, q2, r2, dz);
      checkResult2("t4b", 4'd4, 2'd1, lat, q2, r2, dz);

      // Reset two iterations into 13/2; outputs still hold 4/1 beforehand.
      in_valid2 = 1'b1; dividend2 = 4'd13; divisor2 = 2'd2;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5 reset", 32'({in_ready2, out_valid2, dz2, quotient2, remainder2}),
                  32'({1'b1, 1'b0, 1'b0, 4'd0, 2'd0}));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t5 after", 32'({in_ready2, out_valid2}), 32'(2'b10));
      applyStimulus2(4'd13, 2'd2, 0, 0, lat, q2, r2, dz);
      checkResult2("t5", 4'd13, 2'd2, lat, q2, r2, dz);

      applyStimulus4(8'd255, 4'd1, 0, 0, lat, q4, r4, dz);
      checkResult4("max", 8'd255, 4'd1, lat, q4, r4, dz);
      applyStimulus4(8'd225, 4'd15, 0, 0, lat, q4, r4, dz);
      checkResult4("prod", 8'd225, 4'd15, lat, q4, r4, dz);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 4; b++) begin
            applyStimulus2(4'(a), 2'(b), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                           lat, q2, r2, dz);
            checkResult2("sw2", 4'(a), 2'(b), lat, q2, r2, dz);
         end
      end

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            applyStimulus4(8'(a), 4'(b), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           lat, q4, r4, dz);
            checkResult4("sw4", 8'(a), 4'(b), lat, q4, r4, dz);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
